// File: rtl/simplespislave.sv
// simplespislave: SPI mode-0 slave, fully oversampled in the clk domain.
// The CPU side has one TX holding register and one RX data register.
// Both registers carry sticky overrun/underrun flags.
`timescale 1ns/1ps

module simplespislave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_we,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_rd,
    output logic       rx_overrun,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Synchronizer chains. Each chain shifts left, and the MSB is the synced value.
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;

    logic w_sck_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sck_rise;
    logic w_sck_fall;

    state_t r_state;
    state_t w_next_state;

    logic       w_load;      // move the holding reg (or the fill byte) into shift_tx
    logic       w_sample;    // capture one mosi bit
    logic       w_shift;     // advance shift_tx to the next miso bit
    logic       w_go_idle;   // chip select released mid-frame
    logic [7:0] w_load_byte;

    logic [7:0] r_shift_tx;
    logic [7:0] r_shift_rx;
    logic [2:0] r_bit_cnt;
    logic       r_byte_done;

    logic [7:0] r_hold;
    logic       r_tx_ready;
    logic       r_tx_underrun;

    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_overrun;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;

    // An empty holding register means the master gets the fill byte.
    assign w_load_byte = r_tx_ready ? FILL_BYTE : r_hold;

    // Bring the asynchronous SPI pins into clk and keep a delayed sck for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample its pre-edge input; blocking would collapse the chain.
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= w_sck_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next state, plus the per-clock datapath strobes derived from synced pins.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_next_state = r_state;
        w_load       = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        w_go_idle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_s) begin
                    w_load       = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_s) begin
                    w_go_idle    = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_sample = w_sck_rise;
                    if (w_sck_fall) begin
                        if (r_bit_cnt == 3'd0) w_load  = 1'b1;
                        else                   w_shift = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Shift registers and bit counter. bit_cnt wraps 7->0 on the byte's last sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift_tx  <= '0;
            r_shift_rx  <= '0;
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= w_sample && (r_bit_cnt == 3'd7);
            if (w_load)       r_shift_tx <= w_load_byte;
            else if (w_shift) r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            if (w_sample)     r_shift_rx <= {r_shift_rx[6:0], w_mosi_s};
            if (w_go_idle || (r_state == ST_IDLE)) r_bit_cnt <= '0;
            else if (w_sample)                      r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // TX holding register. A load frees it; a write is accepted only while it is empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold        <= '0;
            r_tx_ready    <= 1'b1;
            r_tx_underrun <= 1'b0;
        end else begin
            if (w_load && r_tx_ready) r_tx_underrun <= 1'b1;
            else if (tx_we)           r_tx_underrun <= 1'b0;
            if (w_load && !r_tx_ready) begin
                r_tx_ready <= 1'b1;
            end else if (tx_we && r_tx_ready) begin
                r_hold     <= tx_data;
                r_tx_ready <= 1'b0;
            end
        end
    end

    // RX register. A completed byte always wins over a concurrent CPU read.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else if (r_byte_done) begin
            r_rx_data  <= r_shift_rx;
            r_rx_valid <= 1'b1;
            if (rx_rd)           r_rx_overrun <= 1'b0;
            else if (r_rx_valid) r_rx_overrun <= 1'b1;
        end else if (rx_rd) begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end
    end

    assign miso        = (r_state == ST_SHIFT) ? r_shift_tx[7] : 1'b1;
    assign tx_ready    = r_tx_ready;
    assign tx_underrun = r_tx_underrun;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign busy        = ~w_cs_s;

endmodule

// File: tb/tb_simplespislave.sv
// tb_simplespislave: directed and randomized SPI mode-0 master plus CPU stimulus.
// A transaction-level reference model predicts the values checked at each step.
`timescale 1ns/1ps

module tb_simplespislave;

    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] FILL        = 8'hFF;
    localparam int         HALF        = 8;     // clk cycles per sck half-period

    logic       clk;
    logic       resetn;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_we;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       busy;

    simplespislave #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILL_BYTE   (FILL)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .sck         (sck),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_we       (tx_we),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_rd       (rx_rd),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: CPU-visible state and the byte the slave will shift out next.
    bit         m_hold_full;
    logic [7:0] m_hold;
    logic [7:0] m_cur_tx;
    logic [7:0] m_rx_data;
    bit         m_rx_valid;
    bit         m_overrun;
    bit         m_underrun;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_hold_full = 1'b0;
        m_hold      = '0;
        m_cur_tx    = FILL;
        m_rx_data   = '0;
        m_rx_valid  = 1'b0;
        m_overrun   = 1'b0;
        m_underrun  = 1'b0;
    endtask

    // The slave picks its next outgoing byte: held data if any, else the fill byte.
    task automatic model_load();
        if (m_hold_full) begin
            m_cur_tx    = m_hold;
            m_hold_full = 1'b0;
        end else begin
            m_cur_tx   = FILL;
            m_underrun = 1'b1;
        end
    endtask

    task automatic cpu_write(input logic [7:0] d);
        tx_data = d;
        tx_we   = 1'b1;
        wait_clks(1);
        tx_we   = 1'b0;
        if (!m_hold_full) begin
            m_hold      = d;
            m_hold_full = 1'b1;
        end
        m_underrun = 1'b0;
    endtask

    task automatic cpu_read();
        rx_rd = 1'b1;
        wait_clks(1);
        rx_rd = 1'b0;
        m_rx_valid = 1'b0;
        m_overrun  = 1'b0;
    endtask

    task automatic begin_frame(input string tag);
        cs_n = 1'b0;
        wait_clks(HALF);
        model_load();
        check($sformatf("%s.busy_on", tag), 32'(busy), 1);
        check($sformatf("%s.miso_first", tag), 32'(miso), 32'(m_cur_tx[7]));
        check($sformatf("%s.tx_ready_load", tag), 32'(tx_ready), 32'(!m_hold_full));
    endtask

    task automatic end_frame(input string tag);
        wait_clks(HALF);
        cs_n = 1'b1;
        wait_clks(HALF);
        check($sformatf("%s.miso_idle", tag), 32'(miso), 1);
        check($sformatf("%s.busy_off", tag), 32'(busy), 0);
    endtask

    // Mode-0 master: mosi changes while sck is low, and miso is sampled just before each rise.
    // With rd_end set, rx_rd is pulsed in the clk where the last sampled bit lands in rx_data.
    task automatic shift_bits(input logic [7:0] tx, input int nbits, input bit rd_end,
                              output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clks(HALF);
            got[7-i] = miso;
            sck = 1'b1;
            if (rd_end && (i == 7)) begin
                wait_clks(SYNC_STAGES + 1);
                rx_rd = 1'b1;
                wait_clks(1);
                rx_rd = 1'b0;
                wait_clks(HALF - SYNC_STAGES - 2);
            end else begin
                wait_clks(HALF);
            end
            sck = 1'b0;
        end
    endtask

    task automatic do_byte(input string tag, input logic [7:0] tx, input bit rd_end);
        logic [7:0] got;
        logic [7:0] exp_miso;
        exp_miso = m_cur_tx;
        shift_bits(tx, 8, rd_end, got);
        if (rd_end)          m_overrun = 1'b0;
        else if (m_rx_valid) m_overrun = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_data  = tx;
        if (rd_end) m_rx_valid = 1'b1;
        wait_clks(6);
        model_load();
        check($sformatf("%s.miso_byte", tag), 32'(got), 32'(exp_miso));
        check($sformatf("%s.rx_data", tag), 32'(rx_data), 32'(m_rx_data));
        check($sformatf("%s.rx_valid", tag), 32'(rx_valid), 32'(m_rx_valid));
        check($sformatf("%s.rx_overrun", tag), 32'(rx_overrun), 32'(m_overrun));
        check($sformatf("%s.tx_underrun", tag), 32'(tx_underrun), 32'(m_underrun));
        check($sformatf("%s.tx_ready", tag), 32'(tx_ready), 32'(!m_hold_full));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] got;
        resetn  = 1'b0;
        sck     = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        tx_data = '0;
        tx_we   = 1'b0;
        rx_rd   = 1'b0;
        model_reset();
        wait_clks(3);
        check("rst.miso", 32'(miso), 1);
        check("rst.tx_ready", 32'(tx_ready), 1);
        check("rst.rx_data", 32'(rx_data), 0);
        check("rst.rx_valid", 32'(rx_valid), 0);
        check("rst.rx_overrun", 32'(rx_overrun), 0);
        check("rst.tx_underrun", 32'(tx_underrun), 0);
        check("rst.busy", 32'(busy), 0);
        resetn = 1'b1;
        wait_clks(2);

        // 1: single byte with a preloaded reply
        cpu_write(8'h3C);
        check("t1.tx_ready_full", 32'(tx_ready), 0);
        begin_frame("t1");
        do_byte("t1", 8'hA5, 1'b0);
        check("t1.rx_a5", 32'(rx_data), 32'h0000_00A5);
        end_frame("t1");

        // 2: 4-byte burst, CPU refills and reads once per byte.
        // The spare 0xF4 covers the reload at the final byte boundary; cs_n rise then discards it.
        cpu_write(8'hF0);
        begin_frame("t2");
        for (int i = 0; i < 4; i++) begin
            cpu_write(8'hF1 + 8'(i));
            do_byte($sformatf("t2.b%0d", i), 8'h01 + 8'(i), 1'b0);
            cpu_read();
        end
        end_frame("t2");
        check("t2.no_overrun", 32'(rx_overrun), 0);
        check("t2.no_underrun", 32'(tx_underrun), 0);

        // 3: two bytes, no read, no preload
        begin_frame("t3");
        do_byte("t3.b0", 8'h11, 1'b0);
        do_byte("t3.b1", 8'h22, 1'b0);
        end_frame("t3");
        check("t3.rx_22", 32'(rx_data), 32'h0000_0022);
        check("t3.overrun", 32'(rx_overrun), 1);
        check("t3.underrun", 32'(tx_underrun), 1);
        cpu_read();
        check("t3.overrun_clr", 32'(rx_overrun), 0);
        check("t3.valid_clr", 32'(rx_valid), 0);

        // 4: aborted partial byte, then a clean byte
        begin_frame("t4p");
        shift_bits(8'h96, 5, 1'b0, got);
        end_frame("t4p");
        check("t4.valid_after_abort", 32'(rx_valid), 0);
        check("t4.rx_data_kept", 32'(rx_data), 32'(m_rx_data));
        begin_frame("t4");
        do_byte("t4", 8'h5A, 1'b0);
        end_frame("t4");

        // 5: second write while full is dropped; read coincides with byte completion
        cpu_write(8'h77);
        cpu_write(8'h88);
        check("t5.tx_ready_full", 32'(tx_ready), 0);
        begin_frame("t5");
        do_byte("t5.b0", 8'h12, 1'b0);
        do_byte("t5.b1", 8'h34, 1'b1);
        check("t5.valid_kept", 32'(rx_valid), 1);
        check("t5.overrun_clr", 32'(rx_overrun), 0);
        end_frame("t5");

        // 6: asynchronous reset mid-byte, then a fresh transfer
        begin_frame("t6p");
        cpu_write(8'h99);
        shift_bits(8'hE7, 4, 1'b0, got);
        #3 resetn = 1'b0;
        #1;
        check("t6.rst_miso", 32'(miso), 1);
        check("t6.rst_tx_ready", 32'(tx_ready), 1);
        check("t6.rst_rx_data", 32'(rx_data), 0);
        check("t6.rst_rx_valid", 32'(rx_valid), 0);
        check("t6.rst_overrun", 32'(rx_overrun), 0);
        check("t6.rst_underrun", 32'(tx_underrun), 0);
        check("t6.rst_busy", 32'(busy), 0);
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        wait_clks(3);
        resetn = 1'b1;
        model_reset();
        wait_clks(2);
        cpu_write(8'h5E);
        begin_frame("t6");
        do_byte("t6", 8'hC3, 1'b0);
        end_frame("t6");

        // Randomized frames with random CPU traffic between bytes
        for (int f = 0; f < 6; f++) begin
            int nbytes;
            if ($urandom_range(0, 1) == 1) cpu_write(8'($urandom_range(0, 255)));
            begin_frame($sformatf("r%0d", f));
            nbytes = $urandom_range(1, 3);
            for (int b = 0; b < nbytes; b++) begin
                do_byte($sformatf("r%0d.b%0d", f, b), 8'($urandom_range(0, 255)), 1'b0);
                if ($urandom_range(0, 1) == 1) cpu_write(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 2) == 0) cpu_read();
            end
            end_frame($sformatf("r%0d", f));
            check($sformatf("r%0d.rx_valid_end", f), 32'(rx_valid), 32'(m_rx_valid));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
